// File: rtl/eth_link_mon_pkg.sv
// Shared types and helpers for the per-lane 10G link supervisor.
// Flap statistics are built only when ETH_LINK_MON_STATS_EN is defined.
package eth_link_mon_pkg;

  typedef enum logic [2:0] {
    DOWN,
    UP_WAIT,
    UP,
    DOWN_WAIT,
    RST_REQ
  } lane_state_t;

  localparam int FLAP_CNT_W = 16;

  function automatic int cnt_w(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/eth_link_lane_fsm.sv
// One lane: lock synchroniser, debounce/timeout FSM, retries, flap counter.
// Flap counter exists only under ETH_LINK_MON_STATS_EN.
module eth_link_lane_fsm
  import eth_link_mon_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES    = 1024,
  parameter int RELOCK_TIMEOUT     = 2**20,
  parameter int RESET_PULSE_CYCLES = 16,
  parameter int MAX_RETRIES        = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  lock_raw,
  input  logic                  stats_clr,
  output logic                  link_up,
  output logic                  rst_req,
  output logic                  failed,
  output logic [FLAP_CNT_W-1:0] flap_cnt
);

  localparam int DW = cnt_w(DEBOUNCE_CYCLES);
  localparam int TW = cnt_w(RELOCK_TIMEOUT);
  localparam int PW = cnt_w(RESET_PULSE_CYCLES);
  localparam int RW = cnt_w(MAX_RETRIES);

  localparam logic [DW-1:0] DEB_END = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] TMO_END = TW'(RELOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(RELOCK_TIMEOUT);
  localparam logic [PW-1:0] PUL_END = PW'(RESET_PULSE_CYCLES - 1);
  localparam logic [RW-1:0] RET_MAX = RW'(MAX_RETRIES);

  lane_state_t   state, state_n;
  logic          sync1, lock_s;
  logic [DW-1:0] deb, deb_n;
  logic [TW-1:0] tmo, tmo_n, tmo_inc;
  logic [PW-1:0] pcnt, pcnt_n;
  logic [RW-1:0] retry, retry_n;
  logic          failed_q, failed_n;
  logic          link_q;
  logic          flap_inc;
  logic          tmo_hit;

  assign tmo_inc = (tmo == TMO_MAX) ? tmo : tmo + 1'b1;
  assign tmo_hit = (tmo >= TMO_END);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1    <= 1'b0;
      lock_s   <= 1'b0;
      state    <= DOWN;
      deb      <= '0;
      tmo      <= '0;
      pcnt     <= '0;
      retry    <= '0;
      failed_q <= 1'b0;
      link_q   <= 1'b0;
    end else begin
      sync1    <= lock_raw;
      lock_s   <= sync1;
      state    <= state_n;
      deb      <= deb_n;
      tmo      <= tmo_n;
      pcnt     <= pcnt_n;
      retry    <= retry_n;
      failed_q <= failed_n;
      link_q   <= (state == UP) || (state == DOWN_WAIT);
    end
  end

  // A lock change in the expiry cycle is tested first, so it wins.
  always_comb begin
    state_n  = state;
    deb_n    = deb;
    tmo_n    = tmo;
    pcnt_n   = '0;
    retry_n  = retry;
    failed_n = failed_q;
    flap_inc = 1'b0;
    unique case (state)
      DOWN: begin
        tmo_n = tmo_inc;
        if (lock_s) begin
          state_n = UP_WAIT;
          deb_n   = '0;
        end else if (tmo_hit && (retry < RET_MAX)) begin
          state_n = RST_REQ;
        end else if (tmo_hit) begin
          failed_n = 1'b1;
          tmo_n    = '0;
        end
      end
      UP_WAIT: begin
        tmo_n = tmo_inc;
        deb_n = deb + 1'b1;
        if (!lock_s) begin
          state_n = DOWN;
        end else if (deb == DEB_END) begin
          state_n  = UP;
          retry_n  = '0;
          tmo_n    = '0;
          failed_n = 1'b0;
        end
      end
      UP: begin
        if (!lock_s) begin
          state_n = DOWN_WAIT;
          deb_n   = '0;
        end
      end
      DOWN_WAIT: begin
        deb_n = deb + 1'b1;
        if (lock_s) begin
          state_n = UP;
        end else if (deb == DEB_END) begin
          state_n  = DOWN;
          tmo_n    = '0;
          flap_inc = 1'b1;
        end
      end
      RST_REQ: begin
        pcnt_n = pcnt + 1'b1;
        if (pcnt == PUL_END) begin
          state_n = DOWN;
          tmo_n   = '0;
          pcnt_n  = '0;
          if (retry != RET_MAX) retry_n = retry + 1'b1;
        end
      end
      default: state_n = DOWN;
    endcase
  end

  always_comb begin
    rst_req = (state == RST_REQ);
    link_up = link_q;
    failed  = failed_q;
  end

`ifdef ETH_LINK_MON_STATS_EN
  logic [FLAP_CNT_W-1:0] flap_q;

  // Clear beats a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || stats_clr) begin
      flap_q <= '0;
    end else if (flap_inc && (flap_q != '1)) begin
      flap_q <= flap_q + 1'b1;
    end
  end

  assign flap_cnt = flap_q;
`else
  logic unused_stats;

  assign unused_stats = stats_clr ^ flap_inc;
  assign flap_cnt     = '0;
`endif

endmodule

// File: rtl/eth_link_monitor.sv
// Multi-lane 10G link supervisor: one lane FSM per GT lane plus all_up.
// Define ETH_LINK_MON_STATS_EN to build per-lane flap counters.
module eth_link_monitor
  import eth_link_mon_pkg::*;
#(
  parameter int NUM_LANES          = 2,
  parameter int DEBOUNCE_CYCLES    = 1024,
  parameter int RELOCK_TIMEOUT     = 2**20,
  parameter int RESET_PULSE_CYCLES = 16,
  parameter int MAX_RETRIES        = 7
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_LANES-1:0]            rx_block_lock,
  output logic [NUM_LANES-1:0]            link_up,
  output logic                            all_up,
  output logic [NUM_LANES-1:0]            lane_rst_req,
  output logic [NUM_LANES-1:0]            lane_failed,
  output logic [NUM_LANES-1:0]            led,
  input  logic                            stats_clr,
  output logic [FLAP_CNT_W*NUM_LANES-1:0] flap_cnt
);

  for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
    eth_link_lane_fsm #(
      .DEBOUNCE_CYCLES    (DEBOUNCE_CYCLES),
      .RELOCK_TIMEOUT     (RELOCK_TIMEOUT),
      .RESET_PULSE_CYCLES (RESET_PULSE_CYCLES),
      .MAX_RETRIES        (MAX_RETRIES)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .lock_raw  (rx_block_lock[n]),
      .stats_clr (stats_clr),
      .link_up   (link_up[n]),
      .rst_req   (lane_rst_req[n]),
      .failed    (lane_failed[n]),
      .flap_cnt  (flap_cnt[FLAP_CNT_W*n +: FLAP_CNT_W])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) all_up <= 1'b0;
    else     all_up <= &link_up;
  end

  assign led = link_up;

endmodule

// File: tb/tb_eth_link_monitor.sv
// Bench for eth_link_monitor: table, directed corner cases, random vs model.
// Honours ETH_LINK_MON_STATS_EN for flap counter expectations.
module tb_eth_link_monitor;

  localparam int NL  = 2;
  localparam int DEB = 4;
  localparam int RT  = 32;
  localparam int RP  = 3;
  localparam int MR  = 2;
`ifdef ETH_LINK_MON_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  localparam int P_DOWN = 0;
  localparam int P_UPW  = 1;
  localparam int P_UP   = 2;
  localparam int P_DNW  = 3;
  localparam int P_RST  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          stats_clr = 1'b0;
  logic [NL-1:0] rx = '0;
  logic [NL-1:0] link_up, lane_rst_req, lane_failed, led;
  logic          all_up;
  logic [16*NL-1:0] flap_cnt;

  int checks = 0;
  int errors = 0;
  int t = 0;
  bit cmp_en = 1'b0;

  always #4 clk = ~clk;

  eth_link_monitor #(
    .NUM_LANES          (NL),
    .DEBOUNCE_CYCLES    (DEB),
    .RELOCK_TIMEOUT     (RT),
    .RESET_PULSE_CYCLES (RP),
    .MAX_RETRIES        (MR)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_block_lock (rx),
    .link_up       (link_up),
    .all_up        (all_up),
    .lane_rst_req  (lane_rst_req),
    .lane_failed   (lane_failed),
    .led           (led),
    .stats_clr     (stats_clr),
    .flap_cnt      (flap_cnt)
  );

  // Reference model: each lane's phase, time spent in it, and time
  // since it last reached UP, advanced once per clock.
  int            m_ph [NL];
  int            m_dwell [NL];
  int            m_idle [NL];
  int            m_tries [NL];
  int            m_flap [NL];
  bit            m_fail [NL];
  bit            m_pipe [NL][2];
  logic [NL-1:0] m_lu;
  logic          m_all;

  always @(posedge clk) begin
    if (rst) begin
      for (int l = 0; l < NL; l++) begin
        m_ph[l] = P_DOWN; m_dwell[l] = 0; m_idle[l] = 0;
        m_tries[l] = 0; m_flap[l] = 0; m_fail[l] = 0;
        m_pipe[l][0] = 0; m_pipe[l][1] = 0;
      end
      m_lu = '0;
      m_all = 1'b0;
    end else begin
      m_all = &m_lu;
      for (int l = 0; l < NL; l++) begin
        bit ls;
        ls = m_pipe[l][1];
        m_lu[l] = (m_ph[l] == P_UP) || (m_ph[l] == P_DNW);
        case (m_ph[l])
          P_DOWN:
            if (ls) begin
              m_ph[l] = P_UPW; m_dwell[l] = 0; m_idle[l]++;
            end else if (m_idle[l] >= RT - 1) begin
              if (m_tries[l] < MR) begin
                m_ph[l] = P_RST; m_dwell[l] = 0;
              end else begin
                m_fail[l] = 1; m_idle[l] = 0;
              end
            end else m_idle[l]++;
          P_UPW:
            if (!ls) begin
              m_ph[l] = P_DOWN; m_idle[l]++;
            end else if (m_dwell[l] == DEB - 1) begin
              m_ph[l] = P_UP; m_tries[l] = 0;
              m_idle[l] = 0; m_fail[l] = 0;
            end else begin
              m_dwell[l]++; m_idle[l]++;
            end
          P_UP:
            if (!ls) begin
              m_ph[l] = P_DNW; m_dwell[l] = 0;
            end
          P_DNW:
            if (ls) m_ph[l] = P_UP;
            else if (m_dwell[l] == DEB - 1) begin
              m_ph[l] = P_DOWN; m_idle[l] = 0;
              if (STATS && m_flap[l] < 65535) m_flap[l]++;
            end else m_dwell[l]++;
          default:
            if (m_dwell[l] == RP - 1) begin
              m_ph[l] = P_DOWN; m_idle[l] = 0;
              if (m_tries[l] < MR) m_tries[l]++;
            end else m_dwell[l]++;
        endcase
        if (STATS && stats_clr) m_flap[l] = 0;
        m_pipe[l][1] = m_pipe[l][0];
        m_pipe[l][0] = rx[l];
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", name, act, exp, t);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic tick_to(input int n);
    while (t < n) tick();
  endtask

  task automatic do_reset;
    rst = 1'b1; rx = '0; stats_clr = 1'b0;
    tick(); tick();
    rst = 1'b0;
    t = 0;
  endtask

  // Watch lane0 for a window: reset pulse cycles, pulse starts, first failure.
  task automatic watch_lane0(input int n, output int req_n, output int s1,
                             output int s2, output int fail_t,
                             output int late);
    req_n = 0; s1 = -1; s2 = -1; fail_t = -1; late = 0;
    for (int k = 0; k < n; k++) begin
      tick();
      if (lane_rst_req[0]) begin
        req_n++;
        if (s1 < 0) s1 = t;
        else if (t > s1 + RP && s2 < 0) s2 = t;
        if (fail_t >= 0) late++;
      end
      if (lane_failed[0] && fail_t < 0) fail_t = t;
    end
  endtask

  typedef struct {
    logic [1:0] lock;
    int         hold;
    logic [1:0] lu;
    logic       all;
  } vec_t;

  vec_t tbl [9];

  initial begin
    int req_n, s1, s2, fail_t, late;
    logic [1:0] acc;
    int rem [NL];

    tbl[0] = '{2'b11, 10, 2'b11, 1'b1};
    tbl[1] = '{2'b01,  3, 2'b11, 1'b1};
    tbl[2] = '{2'b11, 10, 2'b11, 1'b1};
    tbl[3] = '{2'b10, 12, 2'b10, 1'b0};
    tbl[4] = '{2'b11, 12, 2'b11, 1'b1};
    tbl[5] = '{2'b00, 12, 2'b00, 1'b0};
    tbl[6] = '{2'b00, 40, 2'b00, 1'b0};
    tbl[7] = '{2'b01,  4, 2'b00, 1'b0};
    tbl[8] = '{2'b01, 10, 2'b01, 1'b0};

    do_reset();
    chk("reset_outputs",
        {link_up, all_up, lane_rst_req, lane_failed, led, flap_cnt}, '0);

    do_reset();
    foreach (tbl[i]) begin
      rx = tbl[i].lock;
      repeat (tbl[i].hold) tick();
      chk($sformatf("tbl%0d_link_up", i), link_up, tbl[i].lu);
      chk($sformatf("tbl%0d_all_up", i), all_up, tbl[i].all);
    end

    // Lock lane0 captured at cycle 10: link_up exactly at 17.
    do_reset();
    tick_to(9);
    rx = 2'b01;
    tick_to(16);
    chk("t1_link_early", link_up, 2'b00);
    tick_to(17);
    chk("t1_link_rise", link_up, 2'b01);
    chk("t1_led", led, 2'b01);
    chk("t1_all_up", all_up, 1'b0);
    chk("t1_rst_req", lane_rst_req, 2'b00);

    // Lane1 glitches of 3 and 5 cycles.
    do_reset();
    rx = 2'b11;
    tick_to(12);
    chk("t2_both_up", {link_up, all_up}, 3'b111);
    rx = 2'b01;
    acc = 2'b11;
    for (int k = 0; k < 13; k++) begin
      if (t == 15) rx = 2'b11;
      tick();
      acc = acc & link_up;
    end
    chk("t2_short_drop_holds", acc, 2'b11);
    chk("t2_flap_short", flap_cnt[31:16], 16'd0);
    rx = 2'b01;
    tick_to(30);
    rx = 2'b11;
    tick_to(32);
    chk("t2_long_drop_still_up", link_up, 2'b11);
    tick_to(33);
    chk("t2_long_drop_fall", link_up, 2'b01);
    chk("t2_flap_long", flap_cnt[31:16], STATS ? 16'd1 : 16'd0);

    // Never locks: two pulses, then failure, then recovery.
    do_reset();
    watch_lane0(140, req_n, s1, s2, fail_t, late);
    chk("t3_req_cycles", req_n, 6);
    chk("t3_pulse1_start", s1, 32);
    chk("t3_pulse2_start", s2, 67);
    chk("t3_fail_time", fail_t, 102);
    chk("t3_no_pulse_after_fail", late, 0);
    rx = 2'b01;
    tick_to(146);
    chk("t3_fail_sticky", lane_failed[0], 1'b1);
    tick_to(147);
    chk("t3_fail_clear_on_up", lane_failed[0], 1'b0);
    tick_to(148);
    chk("t3_link_after_fail", link_up[0], 1'b1);

    // Lock drops exactly on UP_WAIT expiry.
    do_reset();
    tick_to(4);
    rx = 2'b01;
    tick_to(8);
    rx = 2'b00;
    acc = 2'b00;
    for (int k = 0; k < 22; k++) begin
      tick();
      acc = acc | link_up;
    end
    chk("t4_tie_stays_down", acc, 2'b00);
    // One cycle later the lane does reach UP and then debounces down.
    do_reset();
    tick_to(4);
    rx = 2'b01;
    tick_to(9);
    rx = 2'b00;
    tick_to(11);
    chk("t4_up_pre", link_up[0], 1'b0);
    tick_to(12);
    chk("t4_up_rise", link_up[0], 1'b1);
    tick_to(16);
    chk("t4_up_hold", link_up[0], 1'b1);
    tick_to(17);
    chk("t4_up_fall", link_up[0], 1'b0);
    chk("t4_flap", flap_cnt[15:0], STATS ? 16'd1 : 16'd0);

    // Reset in the 2nd cycle of the 2nd pulse; retries restart.
    do_reset();
    tick_to(68);
    chk("t5_pulse_on", lane_rst_req[0], 1'b1);
    rst = 1'b1;
    tick();
    chk("t5_abort_outputs",
        {link_up, all_up, lane_rst_req, lane_failed, flap_cnt}, '0);
    rst = 1'b0;
    t = 0;
    watch_lane0(110, req_n, s1, s2, fail_t, late);
    chk("t5_req_cycles", req_n, 6);
    chk("t5_pulse1_start", s1, 32);
    chk("t5_fail_time", fail_t, 102);

    // stats_clr coincident with a flap.
    do_reset();
    rx = 2'b01;
    tick_to(10);
    rx = 2'b00;
    tick_to(16);
    chk("t6_pre_flap", flap_cnt[15:0], 16'd0);
    stats_clr = 1'b1;
    tick_to(17);
    stats_clr = 1'b0;
    chk("t6_link_fall", link_up[0], 1'b1);
    chk("t6_clr_wins", flap_cnt[15:0], 16'd0);
    rx = 2'b01;
    tick_to(30);
    rx = 2'b00;
    tick_to(40);
    chk("t6_flap_after", flap_cnt[15:0], STATS ? 16'd1 : 16'd0);

    // Random lock runs, occasional stats_clr and rst, vs model.
    do_reset();
    cmp_en = 1'b1;
    foreach (rem[l]) rem[l] = 0;
    for (int k = 0; k < 3000; k++) begin
      for (int l = 0; l < NL; l++) begin
        if (rem[l] == 0) begin
          rx[l] = ~rx[l];
          if ($urandom_range(0, 3) == 0)
            rem[l] = rx[l] ? $urandom_range(20, 60) : $urandom_range(30, 130);
          else
            rem[l] = $urandom_range(1, 9);
        end
        rem[l]--;
      end
      stats_clr = ($urandom_range(0, 63) == 0);
      rst = ($urandom_range(0, 999) == 0);
      tick();
      chk("rand_outputs",
          {link_up, all_up, lane_rst_req, lane_failed, led, flap_cnt},
          {m_lu, m_all,
           m_ph[1] == P_RST, m_ph[0] == P_RST,
           m_fail[1], m_fail[0], m_lu,
           16'(m_flap[1]), 16'(m_flap[0])});
    end
    cmp_en = 1'b0;
    rst = 1'b0;
    stats_clr = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
